gray_decoder_seq: RTL and testbench
===================================

Name: gray_decoder_seq

Overview:
Sequential Gray-to-binary decoder. It is the receive-side counterpart to the team's combinational binary-to-Gray encoder.
- Accepts one Gray code word per valid/ready handshake.
- Decodes bit-serially, MSB to LSB, one bit per clock.
- Presents the binary result on a valid/ready output port.
- Sits downstream of Gray-coded counters and pointers where area matters more than throughput.

Parameters:
WIDTH, 4, code width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
in_valid  input  1  in_gray holds a valid word.
in_ready  output  1  decoder can accept a word.
in_gray  input  WIDTH  Gray-coded input word.
out_valid  output  1  out_binary holds a decoded result.
out_ready  input  1  consumer accepts the result.
out_binary  output  WIDTH  decoded binary word.
busy  output  1  high in DECODE or HOLD.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE, out_valid=0, out_binary=0, busy=0, bit index=0, internal Gray register=0. in_ready=1 in the first cycle after reset.
- Reset mid-operation aborts any decode or held result immediately. No output handshake occurs for the aborted word.
- State IDLE:
  - in_ready=1.
  - Transfer occurs on an edge with in_valid&in_ready.
  - On transfer: capture in_gray; set out_binary[WIDTH-1]=in_gray[WIDTH-1] and clear the remaining bits; set idx=WIDTH-2.
  - Next state is DECODE, or HOLD if WIDTH==1.
- State DECODE:
  - in_ready=0, out_valid=0.
  - Each cycle: out_binary[idx] = out_binary[idx+1] XOR g[idx].
  - If idx==0, go to HOLD; otherwise decrement idx.
- State HOLD:
  - out_valid=1, in_ready=0.
  - out_binary is held stable while out_ready=0, for any number of cycles.
  - On out_valid&out_ready, go to IDLE; out_valid drops the next cycle.
- Latency: out_valid rises WIDTH-1 edges after the accept edge (WIDTH=4: 3 cycles; WIDTH=1: next cycle).
- Throughput: one word per WIDTH+1 cycles minimum: accept, WIDTH-1 decode, handshake, return to IDLE.
- in_valid while not in IDLE is ignored. The producer must hold the word until it is accepted.
- in_gray changing during DECODE has no effect, because the word was captured at accept.
- idx width is clog2(WIDTH), minimum 1. No wrap-around: idx never decrements below 0.
- Result equals the combinational reference b[i] = XOR of g[WIDTH-1:i], for all inputs.

Optional Feature:
Macro GRAY_STEP_CHECK_EN enables Gray step checking.
- Adds output port step_err (1 bit).
- Adds a register holding the previous accepted Gray word plus a have_prev flag; both reset to 0.
- On each accept:
  - If have_prev=1 and popcount(prev XOR new) != 1, set step_err. A distance of 0, i.e. a repeated word, also counts as an error.
  - Update prev and set have_prev=1.
- step_err is asserted only while out_valid=1 for the offending word and clears with that word's output handshake.
- The first word after reset is never flagged.
- Without the macro: no port, no registers, no behaviour change.

Test Plan:
1. WIDTH=4, reset then in_gray=4'b0110 with in_valid=1, out_ready=1 -> accepted at edge T0, out_valid=1 after edge T3, out_binary=4'b0100, busy high T0..handshake.
2. Exhaustive WIDTH=4: send all 16 Gray words 0000..1000 in sequence -> each out_binary equals the index 0..15; gray 4'b1000 -> 4'b1111.
3. Backpressure: in_gray=4'b0111, hold out_ready=0 for 5 cycles after out_valid -> out_binary=4'b0101 stable, in_ready=0 throughout, in_valid with new data ignored; the word is consumed once out_ready=1.
4. Reset mid-decode: accept 4'b1010, drive rst_n=0 at the second DECODE edge -> next cycle out_valid=0, out_binary=0, in_ready=1; no output handshake for 1010.
5. WIDTH=1: in_gray=1 -> out_valid the next cycle with out_binary=1; WIDTH=8 with in_gray=8'hC0 -> out_binary=8'h80 after 7 cycles.
6. GRAY_STEP_CHECK_EN, WIDTH=4: send 0110, 0111, 0100, 0100 -> step_err=0,0,1,1 (0111->0100 distance 2; repeated word distance 0); after reset, first word 1000 -> step_err=0.

Source files
------------

// File: rtl/gray_decoder_seq.sv
// ============================================================================
// gray_decoder_seq : bit-serial Gray-to-binary decoder, MSB first, valid/ready
// Optional: GRAY_STEP_CHECK_EN adds step_err (unit-distance check on inputs)
// Revision: 1.0
// ============================================================================
`default_nettype none

module gray_decoder_seq #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_binary,
  output logic             busy
`ifdef GRAY_STEP_CHECK_EN
  ,
  output logic             step_err
`endif
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_START = IDX_W'((WIDTH > 1) ? WIDTH - 2 : 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             accept;
  logic             release_w;
  logic [WIDTH-1:0] bin_above;

  assign accept     = (state_q == IDLE) && in_valid;
  assign release_w  = (state_q == HOLD) && out_ready;
  // bin_above[i] is the already-decoded bit i+1, so no idx+1 arithmetic is needed
  assign bin_above  = bin_q >> 1;

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign busy       = (state_q != IDLE);
  assign out_binary = bin_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gray_q  <= '0;
      bin_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      gray_q  <= gray_d;
      bin_q   <= bin_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gray_d  = gray_q;
    bin_d   = bin_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          gray_d           = in_gray;
          bin_d            = '0;
          bin_d[WIDTH-1]   = in_gray[WIDTH-1];
          idx_d            = IDX_START;
          state_d          = (WIDTH == 1) ? HOLD : DECODE;
        end
      end
      DECODE: begin
        bin_d[idx_q] = bin_above[idx_q] ^ gray_q[idx_q];
        if (idx_q == '0) begin
          state_d = HOLD;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      HOLD: begin
        if (release_w) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef GRAY_STEP_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] step_diff;
  logic             unit_step;

  assign step_diff = prev_q ^ in_gray;
  // Exactly one bit differs: non-zero and a power of two
  assign unit_step = (step_diff != '0) && ((step_diff & (step_diff - WIDTH'(1))) == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    err_d       = err_q;
    if (accept) begin
      err_d       = have_prev_q && !unit_step;
      prev_d      = in_gray;
      have_prev_d = 1'b1;
    end else if (release_w) begin
      err_d = 1'b0;
    end
  end

  assign step_err = err_q && (state_q == HOLD);
`endif

endmodule

`default_nettype wire

// File: tb/tb_gray_decoder_seq.sv
// Randomised + directed bench for gray_decoder_seq at WIDTH = 1, 4 and 8.
`default_nettype none

module tb_gray_decoder_seq;

  logic clk;
  logic rst_n;

  logic iv1, ir1, ov1, or1, bz1;
  logic [0:0] ig1, ob1;
  logic iv4, ir4, ov4, or4, bz4;
  logic [3:0] ig4, ob4;
  logic iv8, ir8, ov8, or8, bz8;
  logic [7:0] ig8, ob8;
`ifdef GRAY_STEP_CHECK_EN
  logic se1, se4, se8;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] prev_g [int];
  bit          have_prev [int];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gray_decoder_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .in_gray(ig1),
    .out_valid(ov1), .out_ready(or1), .out_binary(ob1), .busy(bz1)
`ifdef GRAY_STEP_CHECK_EN
    , .step_err(se1)
`endif
  );

  gray_decoder_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .in_gray(ig4),
    .out_valid(ov4), .out_ready(or4), .out_binary(ob4), .busy(bz4)
`ifdef GRAY_STEP_CHECK_EN
    , .step_err(se4)
`endif
  );

  gray_decoder_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .in_gray(ig8),
    .out_valid(ov8), .out_ready(or8), .out_binary(ob8), .busy(bz8)
`ifdef GRAY_STEP_CHECK_EN
    , .step_err(se8)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: search for the binary value whose Gray encoding is g
  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    for (int b = 0; b < (1 << w); b++) begin
      if (((b ^ (b >> 1)) & ((1 << w) - 1)) == int'(g)) return 32'(b);
    end
    return 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] rd_bin(input int w);
    case (w)
      1: return 32'(ob1);
      8: return 32'(ob8);
      default: return 32'(ob4);
    endcase
  endfunction

  function automatic logic rd_ov(input int w);
    case (w) 1: return ov1; 8: return ov8; default: return ov4; endcase
  endfunction

  function automatic logic rd_ir(input int w);
    case (w) 1: return ir1; 8: return ir8; default: return ir4; endcase
  endfunction

  function automatic logic rd_busy(input int w);
    case (w) 1: return bz1; 8: return bz8; default: return bz4; endcase
  endfunction

`ifdef GRAY_STEP_CHECK_EN
  function automatic logic rd_se(input int w);
    case (w) 1: return se1; 8: return se8; default: return se4; endcase
  endfunction
`endif

  task automatic drive(input int w, input logic v, input logic [31:0] g, input logic r);
    case (w)
      1: begin iv1 = v; ig1 = g[0:0]; or1 = r; end
      8: begin iv8 = v; ig8 = g[7:0]; or8 = r; end
      default: begin iv4 = v; ig4 = g[3:0]; or4 = r; end
    endcase
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    have_prev.delete();
  endtask

  // One full word: accept, decode, optional backpressure, handshake
  task automatic transact(input int w, input logic [31:0] g_in, input int hold,
                          output logic [31:0] got);
    logic [31:0] g, exp_b, mask;
    logic        exp_se;
    int          lat;
    mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
    g     = g_in & mask;
    exp_b = gray2bin(g, w);
    exp_se = have_prev.exists(w) && ($countones(prev_g[w] ^ g) != 1);
    prev_g[w]    = g;
    have_prev[w] = 1'b1;

    check("ready_idle", 32'(rd_ir(w)), 32'd1);
    drive(w, 1'b1, g, 1'b0);
    @(posedge clk); #1;
    // new data on in_gray/in_valid while busy must be ignored
    drive(w, 1'b1, $urandom, 1'b0);
    check("busy_accept", 32'(rd_busy(w)), 32'd1);
    check("ready_busy", 32'(rd_ir(w)), 32'd0);
    lat = 0;
    while (!rd_ov(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(w - 1));
    check("result", rd_bin(w), exp_b);
    got = rd_bin(w);
`ifdef GRAY_STEP_CHECK_EN
    check("step_err", 32'(rd_se(w)), 32'(exp_se));
`endif
    for (int i = 0; i < hold; i++) begin
      drive(w, 1'b1, $urandom, 1'b0);
      @(posedge clk); #1;
      check("hold_valid", 32'(rd_ov(w)), 32'd1);
      check("hold_data", rd_bin(w), exp_b);
      check("hold_ready", 32'(rd_ir(w)), 32'd0);
    end
    drive(w, 1'b0, 32'd0, 1'b1);
    @(posedge clk); #1;
    drive(w, 1'b0, 32'd0, 1'b0);
    check("post_valid", 32'(rd_ov(w)), 32'd0);
    check("post_ready", 32'(rd_ir(w)), 32'd1);
    check("post_busy", 32'(rd_busy(w)), 32'd0);
`ifdef GRAY_STEP_CHECK_EN
    check("post_step", 32'(rd_se(w)), 32'd0);
`endif
  endtask

  task automatic rand_run(input int w, input int n);
    logic [31:0] g, got;
    int          bitpos;
    g = $urandom;
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 1) == 1 && have_prev.exists(w)) begin
        bitpos = $urandom_range(0, w - 1);
        g = prev_g[w] ^ (32'd1 << bitpos);
      end else begin
        g = $urandom;
      end
      transact(w, g, $urandom_range(0, 3), got);
    end
  endtask

  initial begin
    logic [31:0] got;
    rst_n = 1'b0;
    drive(1, 1'b0, 32'd0, 1'b0);
    drive(4, 1'b0, 32'd0, 1'b0);
    drive(8, 1'b0, 32'd0, 1'b0);
    do_reset();

    check("rst_valid", 32'(ov4), 32'd0);
    check("rst_bin", 32'(ob4), 32'd0);
    check("rst_ready", 32'(ir4), 32'd1);
    check("rst_busy", 32'(bz4), 32'd0);

    // 0110, 0111 (with backpressure), 0100, 0100
    transact(4, 32'b0110, 0, got);
    check("t1_bin", got, 32'b0100);
    transact(4, 32'b0111, 5, got);
    check("t3_bin", got, 32'b0101);
    transact(4, 32'b0100, 1, got);
    transact(4, 32'b0100, 0, got);

    do_reset();
    transact(4, 32'b1000, 0, got);
    check("t6_first", got, 32'b1111);

    for (int i = 0; i < 16; i++) begin
      transact(4, 32'(i ^ (i >> 1)), 0, got);
      check("exhaustive", got, 32'(i));
    end

    // Abort mid-decode
    drive(4, 1'b1, 32'b1010, 1'b1);
    @(posedge clk); #1;
    drive(4, 1'b0, 32'd0, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    have_prev.delete();
    check("abort_valid", 32'(ov4), 32'd0);
    check("abort_bin", 32'(ob4), 32'd0);
    check("abort_ready", 32'(ir4), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("abort_quiet", 32'(ov4), 32'd0);
    end
    drive(4, 1'b0, 32'd0, 1'b0);

    transact(1, 32'd1, 0, got);
    check("w1_bin", got, 32'd1);
    transact(8, 32'hC0, 2, got);
    check("w8_bin", got, 32'h80);

    rand_run(1, 20);
    rand_run(4, 60);
    rand_run(8, 60);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
